// File: rtl/serdes_symbols_pkg.sv
// Shared 10-bit symbol definitions for the TX scheduler and the RX elastic buffer checks.
package serdes_symbols_pkg;

    // Bit 8 is the K flag, bits 7:0 the byte.
    typedef logic [9:0] symbol_t;

    localparam symbol_t COMMA_SYMBOL = 10'h1BC;
    localparam symbol_t SKIP_SYMBOL  = 10'h1A1;
    localparam symbol_t IDLE_SYMBOL  = 10'h17C;

    typedef enum logic {STREAM, SEND_SKP} state_t;

    // Symbols reserved for ordered sets; upstream must never send them as data.
    function automatic logic is_reserved(symbol_t sym);
        return (sym == COMMA_SYMBOL) || (sym == SKIP_SYMBOL);
    endfunction

endpackage

// File: rtl/tx_skp_inserter_if.sv
// Upstream symbol handshake into the SKP inserter.
interface tx_skp_inserter_if;
    import serdes_symbols_pkg::*;

    symbol_t data_in;
    logic    in_valid;
    logic    in_ready;
    logic    force_skp;

    modport master (output data_in, output in_valid, output force_skp, input in_ready);
    modport slave  (input data_in, input in_valid, input force_skp, output in_ready);

endinterface

// File: rtl/skp_interval_timer.sv
// Counts stream symbols between ordered sets and decides when the next set is due.
module skp_interval_timer #(
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic local_clock,
    input  logic reset,
    input  logic i_stream,
    input  logic i_force_skp,
    output logic o_due
);

    localparam int unsigned CntW = $clog2(SKP_INTERVAL);
    localparam logic [CntW-1:0] LastCnt = CntW'(SKP_INTERVAL - 1);

    logic [CntW-1:0] r_interval_cnt;
    logic            r_expired;
    logic            r_force_pending;

    // r_expired marks that the last of SKP_INTERVAL stream symbols has gone out, so the
    // set starts on the following cycle and the gap is exactly SKP_INTERVAL symbols.
    assign o_due = i_stream && (r_expired || r_force_pending || i_force_skp);

    // Interval count, expiry flag and collapsed force request.
    always_ff @(posedge local_clock) begin
        if (!reset) begin
            r_interval_cnt  <= '0;
            r_expired       <= 1'b0;
            r_force_pending <= 1'b0;
        end else if (i_stream) begin
            if (o_due) begin
                r_interval_cnt  <= '0;
                r_expired       <= 1'b0;
                r_force_pending <= 1'b0;
            end else if (r_interval_cnt == LastCnt) begin
                r_expired <= 1'b1;
            end else begin
                r_interval_cnt <= r_interval_cnt + 1'b1;
            end
        end else if (i_force_skp) begin
            r_force_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/tx_skp_inserter.sv
// TX clock-compensation scheduler: forwards symbols and periodically inserts SKP ordered sets.
module tx_skp_inserter
    import serdes_symbols_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_COUNT    = 3
) (
    input  logic                local_clock,
    input  logic                reset,
    tx_skp_inserter_if.slave    bus,
    output symbol_t             data_out,
    output logic                skp_active,
    output logic                illegal_symbol
);

    localparam int unsigned SkpW = $clog2(SKP_COUNT + 1);
    localparam logic [SkpW-1:0] SkpLast = SkpW'(SKP_COUNT - 1);

    state_t          r_state;
    logic [SkpW-1:0] r_skp_cnt;
    symbol_t         r_data_out;
    logic            r_skp_active;
    logic            r_illegal;

    logic w_stream;
    logic w_due;

    assign w_stream = (r_state == STREAM);

    skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_timer (
        .local_clock (local_clock),
        .reset       (reset),
        .i_stream    (w_stream),
        .i_force_skp (bus.force_skp),
        .o_due       (w_due)
    );

    assign bus.in_ready   = reset && w_stream && !w_due;
    assign data_out       = r_data_out;
    assign skp_active     = r_skp_active;
    assign illegal_symbol = r_illegal;

    // Scheduler FSM with registered symbol output.
    always_ff @(posedge local_clock) begin
        if (!reset) begin
            r_state      <= STREAM;
            r_skp_cnt    <= '0;
            r_data_out   <= IDLE_SYMBOL;
            r_skp_active <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            unique case (r_state)
                STREAM: begin
                    if (w_due) begin
                        r_data_out   <= COMMA_SYMBOL;
                        r_skp_active <= 1'b1;
                        r_skp_cnt    <= '0;
                        r_state      <= SEND_SKP;
                    end else begin
                        // Not due and out of reset, so in_ready is high here.
                        r_data_out   <= bus.in_valid ? bus.data_in : IDLE_SYMBOL;
                        r_skp_active <= 1'b0;
                        if (bus.in_valid && is_reserved(bus.data_in)) begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                SEND_SKP: begin
                    r_data_out   <= SKIP_SYMBOL;
                    r_skp_active <= 1'b1;
                    r_skp_cnt    <= r_skp_cnt + 1'b1;
                    if (r_skp_cnt == SkpLast) begin
                        r_state <= STREAM;
                    end
                end
                default: r_state <= STREAM;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Self-checking bench for tx_skp_inserter against a symbol-level schedule model.
module tb_tx_skp_inserter;
    import serdes_symbols_pkg::*;

    localparam int unsigned INTERVAL = 16;
    localparam int unsigned COUNT    = 3;

    logic    clk = 1'b0;
    logic    rst_n;
    symbol_t data_out;
    logic    skp_active;
    logic    illegal_symbol;

    tx_skp_inserter_if bus ();

    tx_skp_inserter #(
        .SKP_INTERVAL (INTERVAL),
        .SKP_COUNT    (COUNT)
    ) dut (
        .local_clock    (clk),
        .reset          (rst_n),
        .bus            (bus),
        .data_out       (data_out),
        .skp_active     (skp_active),
        .illegal_symbol (illegal_symbol)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: gap = stream symbols emitted since the last set, os_left = SKIPs still owed.
    int      m_gap = 0;
    int      m_os_left = 0;
    bit      m_pending = 0;
    bit      m_ready;
    symbol_t exp_out = IDLE_SYMBOL;
    bit      exp_act = 0;
    bit      exp_ill = 0;
    symbol_t d_next = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready, then check the registered outputs.
    task automatic step(input bit rst_v, input bit val_v, input symbol_t dat_v, input bit frc_v);
        rst_n         = rst_v;
        bus.in_valid  = val_v;
        bus.data_in   = dat_v;
        bus.force_skp = frc_v;
        #1;
        if (!rst_v) begin
            m_ready   = 0;
            exp_out   = IDLE_SYMBOL;
            exp_act   = 0;
            exp_ill   = 0;
            m_gap     = 0;
            m_os_left = 0;
            m_pending = 0;
        end else if (m_os_left > 0) begin
            m_ready = 0;
            exp_out = SKIP_SYMBOL;
            exp_act = 1;
            m_os_left--;
            if (frc_v) m_pending = 1;
        end else if (m_gap == INTERVAL || m_pending || frc_v) begin
            m_ready   = 0;
            exp_out   = COMMA_SYMBOL;
            exp_act   = 1;
            m_os_left = COUNT;
            m_gap     = 0;
            m_pending = 0;
        end else begin
            m_ready = 1;
            exp_out = val_v ? dat_v : IDLE_SYMBOL;
            exp_act = 0;
            m_gap++;
            if (val_v && (dat_v == 10'h1BC || dat_v == 10'h1A1)) exp_ill = 1;
        end
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
        @(posedge clk);
        #1;
        check("data_out", {22'd0, data_out}, {22'd0, exp_out});
        check("skp_active", {31'd0, skp_active}, {31'd0, exp_act});
        check("illegal_symbol", {31'd0, illegal_symbol}, {31'd0, exp_ill});
    endtask

    // Incrementing-data step: counter advances only on an accepted symbol.
    task automatic data_step(input bit frc_v);
        step(1'b1, 1'b1, d_next, frc_v);
        if (m_ready) d_next = d_next + 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.force_skp = 1'b0;

        // Reset held with valid data presented.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 10'h055, 1'b0);
            check("rst_data_out", {22'd0, data_out}, 32'h17C);
            check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("rst_skp_active", {31'd0, skp_active}, 32'd0);
        end

        // Periodic insertion with continuous incrementing data.
        d_next = '0;
        for (int k = 0; k < 60; k++) begin
            data_step(1'b0);
            if (k == 0)  check("pin_first_data", {22'd0, data_out}, 32'h000);
            if (k == 15) check("pin_data_15", {22'd0, data_out}, 32'h00F);
            if (k == 16) check("pin_comma_16", {22'd0, data_out}, 32'h1BC);
            if (k == 19) check("pin_skip_19", {22'd0, data_out}, 32'h1A1);
            if (k == 20) check("pin_resume_010", {22'd0, data_out}, 32'h010);
            if (k == 36) check("pin_comma_36", {22'd0, data_out}, 32'h1BC);
        end

        // Idle fill after a fresh reset.
        step(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (k == 15) check("pin_idle_15", {22'd0, data_out}, 32'h17C);
            if (k == 16) check("pin_idle_comma_16", {22'd0, data_out}, 32'h1BC);
            if (k == 36) check("pin_idle_comma_36", {22'd0, data_out}, 32'h1BC);
        end

        // Forced sets, reserved symbol as data, then reset in the middle of a set.
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        d_next = 10'h020;
        for (int k = 0; k < 52; k++) begin
            if (k == 33) step(1'b1, 1'b1, 10'h1A1, 1'b0);
            else data_step(k == 5 || k == 7);
            if (k == 5)  check("pin_force_comma", {22'd0, data_out}, 32'h1BC);
            if (k == 9)  check("pin_pending_comma", {22'd0, data_out}, 32'h1BC);
            if (k == 13) check("pin_after_pending", {31'd0, skp_active}, 32'd0);
            if (k == 29) check("pin_restart_comma", {22'd0, data_out}, 32'h1BC);
            if (k == 33) check("pin_reserved_fwd", {22'd0, data_out}, 32'h1A1);
            if (k == 45) check("pin_illegal_sticky", {31'd0, illegal_symbol}, 32'd1);
            if (k == 51) check("pin_second_skip", {22'd0, data_out}, 32'h1A1);
        end
        step(1'b0, 1'b1, 10'h033, 1'b0);
        check("pin_abort_idle", {22'd0, data_out}, 32'h17C);
        check("pin_abort_active", {31'd0, skp_active}, 32'd0);
        check("pin_illegal_clear", {31'd0, illegal_symbol}, 32'd0);
        step(1'b0, 1'b1, 10'h033, 1'b0);
        for (int k = 0; k < 20; k++) begin
            data_step(1'b0);
            if (k == 15) check("pin_post_abort_data", {31'd0, skp_active}, 32'd0);
            if (k == 16) check("pin_post_abort_comma", {22'd0, data_out}, 32'h1BC);
        end

        // Randomized traffic, forces and occasional resets.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 199) != 0, ($urandom % 4) != 0,
                 symbol_t'($urandom), $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
